// File: rtl/mmio_bus_master.sv
// Initiator for the shared ABUS/DBUS/WE I/O bus: runs MEM-stage loads/stores
// to I/O space and latches device interrupt edges into sticky pending bits.
module mmio_bus_master #(
    parameter int              BITS   = 32,
    parameter logic [BITS-1:0] IOBASE = 32'hFFFFF000,
    parameter int              NINTR  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    input  logic             req_we,
    input  logic [BITS-1:0]  req_addr,
    input  logic [BITS-1:0]  req_wdata,
    output logic             busy,
    output logic             rsp_valid,
    output logic [BITS-1:0]  rsp_rdata,
    output logic [BITS-1:0]  ABUS,
    inout  wire  [BITS-1:0]  DBUS,
    output logic             WE,
    input  logic [NINTR-1:0] dev_intr,
    input  logic [NINTR-1:0] intr_ack,
    output logic [NINTR-1:0] intr_pending,
    output logic             intr_any
);

    typedef enum logic [2:0] {
        IDLE, WR, RD_ADDR, RD_SAMPLE, DONE
    } state_t;

    state_t          state, state_n;
    logic            io_req;
    logic            accept;
    logic [BITS-1:0] addr_q, wdata_q, addr_n;
    logic [BITS-1:0] abus_n;
    logic            we_n, den_n, rsp_n, den_q;
    logic [NINTR-1:0] intr_prev;

    assign io_req = req_valid && (req_addr >= IOBASE);
    assign accept = (state == IDLE) && io_req;

    // Gated by reset so the stall drops the moment a transaction is aborted.
    assign busy = !reset && (accept || state == WR ||
                             state == RD_ADDR || state == RD_SAMPLE);

    assign DBUS = den_q ? wdata_q : 'z;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:      if (io_req) state_n = req_we ? WR : RD_ADDR;
            WR:        state_n = DONE;
            RD_ADDR:   state_n = RD_SAMPLE;
            RD_SAMPLE: state_n = DONE;
            DONE:      state_n = IDLE;
            default:   state_n = IDLE;
        endcase
    end

    // Bus outputs are registered, so they are decoded from the next state.
    assign addr_n = (state == IDLE) ? req_addr : addr_q;

    always_comb begin
        abus_n = '0;
        we_n   = 1'b0;
        den_n  = 1'b0;
        rsp_n  = 1'b0;
        unique case (state_n)
            WR: begin
                abus_n = addr_n;
                we_n   = 1'b1;
                den_n  = 1'b1;
            end
            RD_ADDR, RD_SAMPLE: abus_n = addr_n;
            DONE:               rsp_n  = 1'b1;
            default:            ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ABUS      <= '0;
            WE        <= 1'b0;
            den_q     <= 1'b0;
            rsp_valid <= 1'b0;
        end else begin
            ABUS      <= abus_n;
            WE        <= we_n;
            den_q     <= den_n;
            rsp_valid <= rsp_n;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                   rsp_rdata <= '0;
        else if (state == RD_SAMPLE) rsp_rdata <= DBUS;
    end

    // A new edge wins over a same-cycle ack so it is never lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            intr_prev    <= '0;
            intr_pending <= '0;
        end else begin
            intr_prev    <= dev_intr;
            intr_pending <= (intr_pending & ~intr_ack) |
                            (dev_intr & ~intr_prev);
        end
    end

    assign intr_any = |intr_pending;

endmodule
